// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified IF/DM memory arbiter.
// FAIR_ARB_EN selects the starvation-bounded arbitration variant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Bits needed to hold values 0..maxv, never less than one.
  function automatic int unsigned cnt_width(input int unsigned maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/mem_arb_priority.sv
// Winner select between IF and DM; DM wins unless FAIR_ARB_EN is defined
// and IF has lost STARVE_MAX consecutive contended grants.
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_en,
  output logic if_gnt,
  output logic dm_gnt
);

`ifdef FAIR_ARB_EN
  localparam int unsigned SW = cnt_width(STARVE_MAX);

  logic [SW-1:0] starve;
  logic          force_if;

  assign force_if = (starve == SW'(STARVE_MAX)) && if_req && dm_req;

  always_comb begin
    dm_gnt = grant_en && dm_req && !force_if;
    if_gnt = grant_en && if_req && !dm_gnt;
  end

  // Saturating count of DM wins taken while IF was waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (if_gnt) begin
      starve <= '0;
    end else if (dm_gnt && if_req && (starve != SW'(STARVE_MAX))) begin
      starve <= starve + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{clk, rst_n, STARVE_MAX[0]};

  always_comb begin
    dm_gnt = grant_en && dm_req;
    if_gnt = grant_en && if_req && !dm_req;
  end
`endif

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between IF and DM, one
// transaction outstanding. FAIR_ARB_EN enables bounded IF starvation.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CW = cnt_width(MEM_LAT);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          owner;
  logic          owner_we;
  logic          grant_en;
  logic          any_gnt;
  logic          lat_done;

  assign grant_en = (state == IDLE) || (state == RESP);
  assign any_gnt  = if_gnt || dm_gnt;
  assign lat_done = (cnt == CW'(MEM_LAT));

  mem_arb_priority #(
    .STARVE_MAX(STARVE_MAX)
  ) u_priority (
    .clk     (clk),
    .rst_n   (rst_n),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant_en(grant_en),
    .if_gnt  (if_gnt),
    .dm_gnt  (dm_gnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_gnt ? ISSUE : IDLE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = lat_done ? RESP : WAIT;
      RESP:    state_nxt = any_gnt ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The mem_* registers double as the grant-time request latch: they are
  // loaded on the grant edge, live for the ISSUE cycle, then clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= OWN_IF;
      owner_we  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state <= state_nxt;

      if (any_gnt) begin
        owner     <= dm_gnt ? OWN_DM : OWN_IF;
        owner_we  <= dm_gnt && dm_we;
        mem_en    <= 1'b1;
        mem_we    <= dm_gnt && dm_we;
        mem_addr  <= dm_gnt ? dm_addr : if_addr;
        mem_wdata <= dm_gnt ? dm_wdata : '0;
      end else begin
        mem_en    <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
      end

      if (state == ISSUE) begin
        cnt <= CW'(1);
      end else if ((state == WAIT) && !lat_done) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if ((state == WAIT) && lat_done) begin
        if (owner == OWN_DM) begin
          dm_rdata <= owner_we ? '0 : mem_rdata;
        end else begin
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign if_rvalid = (state == RESP) && (owner == OWN_IF);
  assign dm_rvalid = (state == RESP) && (owner == OWN_DM);
  assign busy      = (state != IDLE);

endmodule
